sipo_capture: RTL and testbench

- Serial-in/parallel-out capture stage that sits directly upstream of the team's D-latch/register bank.
- Shifts a framed serial bit stream (start strobe, WIDTH data bits MSB-first, one even-parity bit) into a word.
- Checks parity, then presents the word with a valid/ready handshake so the downstream latch bank's d/en inputs are driven from a stable, qualified word.

---
 rtl/sipo_pkg.sv | 15 +
 rtl/sipo_shreg.sv | 35 +++
 rtl/sipo_capture.sv | 137 +++++++++++++
 tb/tb_sipo_capture.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out capture stage.
package sipo_pkg;

  // Capture FSM encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Parity sense: 1 = even parity (total ones incl. parity bit must be even).
  localparam logic PARITY_EVEN = 1'b1;

endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit MSB-first shift register with clear, enable and a running
// XOR of every bit shifted in since the last clear.
module sipo_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_din,
  output logic [WIDTH-1:0] o_q,
  output logic             o_par
);

  logic [WIDTH-1:0] r_q;
  logic             r_par;

  // Shift in one bit per enabled cycle; clear wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= '0;
      r_par <= 1'b0;
    end else if (i_clr) begin
      r_q   <= '0;
      r_par <= 1'b0;
    end else if (i_en) begin
      r_q   <= {r_q[WIDTH-2:0], i_din};
      r_par <= r_par ^ i_din;
    end
  end

  assign o_q   = r_q;
  assign o_par = r_par;

endmodule

// File: rtl/sipo_capture.sv
// Framed serial capture: start strobe, WIDTH data bits MSB-first, one parity
// bit. The checked word is held with a valid/ready handshake so the latch bank
// downstream only ever sees a stable, qualified word.
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | accepting data bits
// PARITY | waiting for the parity bit
// HOLD   | word presented, waiting for word_ready
module sipo_capture
  import sipo_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             parity_err,
  output logic             busy,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_word_out;
  logic             r_word_valid;
  logic             r_parity_err;
  logic             r_overrun;

  logic             w_clr;
  logic             w_shift;
  logic             w_capture;
  logic             w_release;
  logic             w_overrun;
  logic [WIDTH-1:0] w_q;
  logic             w_par;

  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_en  (w_shift),
    .i_din (din),
    .o_q   (w_q),
    .o_par (w_par)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SHIFT;
          w_clr       = 1'b1;
        end else if (din_valid) begin
          w_overrun = 1'b1;
        end
      end
      SHIFT: begin
        if (din_valid) begin
          w_shift = 1'b1;
          if (r_count == LAST_BIT) w_state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (din_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_overrun = din_valid;
        if (r_word_valid && word_ready) begin
          w_release = 1'b1;
          if (start) begin
            // back-to-back frame: no IDLE bubble
            w_state_nxt = SHIFT;
            w_clr       = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit counter, held word, handshake flag and overrun pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= '0;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= w_overrun;
      if (w_clr)        r_count <= '0;
      else if (w_shift) r_count <= r_count + CNT_W'(1);
      if (w_capture) begin
        r_word_out   <= w_q;
        r_parity_err <= (w_par ^ din) ^ ~PARITY_EVEN;
        r_word_valid <= 1'b1;
      end else if (w_release) begin
        r_word_valid <= 1'b0;
      end
    end
  end

  assign word_out   = r_word_out;
  assign word_valid = r_word_valid;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state == SHIFT) || (r_state == PARITY);

endmodule

// File: tb/tb_sipo_capture.sv
// Bench for sipo_capture: directed frames plus random stimulus, checked every
// cycle against a frame-level model, with literal checks pinning key results.
module tb_sipo_capture;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset, start, din, din_valid, word_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid, parity_err, busy, overrun;

  int n_vec = 0;
  int n_err = 0;

  sipo_capture #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .parity_err (parity_err),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // ---------------- frame-level model ----------------
  // phase: 0 waiting for start, 1 collecting data, 2 awaiting parity, 3 word held
  int m_phase = 0;
  int m_nbits = 0;
  int m_acc   = 0;
  int m_ones  = 0;
  int e_word  = 0;
  int e_valid = 0;
  int e_perr  = 0;
  int e_ovr   = 0;
  int e_busy  = 0;

  task automatic model_step();
    if (reset) begin
      m_phase = 0; m_nbits = 0; m_acc = 0; m_ones = 0;
      e_word = 0; e_valid = 0; e_perr = 0; e_ovr = 0;
    end else begin
      e_ovr = 0;
      case (m_phase)
        0: begin
          if (start) begin
            m_phase = 1; m_nbits = 0; m_acc = 0; m_ones = 0;
          end else if (din_valid) e_ovr = 1;
        end
        1: begin
          if (din_valid) begin
            m_acc   = (m_acc * 2 + int'(din)) % (1 << WIDTH);
            m_ones += int'(din);
            m_nbits++;
            if (m_nbits == WIDTH) m_phase = 2;
          end
        end
        2: begin
          if (din_valid) begin
            e_word  = m_acc;
            e_perr  = (m_ones + int'(din)) % 2;
            e_valid = 1;
            m_phase = 3;
          end
        end
        default: begin
          if (din_valid) e_ovr = 1;
          if (word_ready) begin
            e_valid = 0;
            if (start) begin
              m_phase = 1; m_nbits = 0; m_acc = 0; m_ones = 0;
            end else m_phase = 0;
          end
        end
      endcase
    end
    e_busy = (m_phase == 1 || m_phase == 2) ? 1 : 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("word_out",   int'(word_out),   e_word);
    chk("word_valid", int'(word_valid), e_valid);
    chk("parity_err", int'(parity_err), e_perr);
    chk("busy",       int'(busy),       e_busy);
    chk("overrun",    int'(overrun),    e_ovr);
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic s, input logic v,
                      input logic d, input logic y);
    reset = r; start = s; din_valid = v; din = d; word_ready = y;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] w, input logic p,
                           input bit stall, input logic y);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      step(1'b0, 1'b0, 1'b1, w[i], y);
      if (stall) begin
        step(1'b0, 1'b0, 1'b0, 1'b0, y);
        chk("busy_stall", int'(busy), 1);
      end
    end
    step(1'b0, 1'b0, 1'b1, p, y);
  endtask

  initial begin
    logic [WIDTH-1:0] w96;
    reset = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0; word_ready = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_valid", int'(word_valid), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_word",  int'(word_out), 0);

    // nominal 0xA5, even parity bit 0
    step(0, 1, 0, 0, 1);
    chk("nom_busy_start", int'(busy), 1);
    send_bits(8'hA5, 1'b0, 0, 1'b1);
    chk("nom_valid", int'(word_valid), 1);
    chk("nom_word",  int'(word_out), 'hA5);
    chk("nom_perr",  int'(parity_err), 0);
    chk("nom_busy",  int'(busy), 0);
    step(0, 0, 0, 0, 1);
    chk("nom_release", int'(word_valid), 0);

    // reset after 3 of 8 bits, then a fresh 0x3C frame
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("mid_rst_busy",  int'(busy), 0);
    chk("mid_rst_valid", int'(word_valid), 0);
    chk("mid_rst_word",  int'(word_out), 0);
    step(0, 1, 0, 0, 0);
    send_bits(8'h3C, 1'b0, 0, 1'b0);
    chk("3c_word", int'(word_out), 'h3C);
    chk("3c_perr", int'(parity_err), 0);
    step(0, 0, 0, 0, 1);

    // 0xFF with wrong parity bit, stalled every other cycle
    step(0, 1, 0, 0, 0);
    send_bits(8'hFF, 1'b1, 1, 1'b0);
    chk("ff_valid", int'(word_valid), 1);
    chk("ff_word",  int'(word_out), 'hFF);
    chk("ff_perr",  int'(parity_err), 1);
    step(0, 0, 0, 0, 1);

    // backpressure with din_valid held high: four overrun pulses
    step(0, 1, 0, 0, 0);
    send_bits(8'h5A, 1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 0, 0);
      chk("bp_overrun", int'(overrun), 1);
      chk("bp_word", int'(word_out), 'h5A);
      chk("bp_valid", int'(word_valid), 1);
    end
    step(0, 0, 0, 0, 1);
    chk("bp_release", int'(word_valid), 0);
    chk("bp_ovr_end", int'(overrun), 0);

    // back-to-back: start on the handshake cycle
    step(0, 1, 0, 0, 0);
    send_bits(8'h3C, 1'b0, 0, 1'b0);
    step(0, 1, 0, 0, 1);
    chk("b2b_busy",  int'(busy), 1);
    chk("b2b_valid", int'(word_valid), 0);
    send_bits(8'h81, 1'b0, 0, 1'b0);
    chk("b2b_valid2", int'(word_valid), 1);
    chk("b2b_word",   int'(word_out), 'h81);
    step(0, 0, 0, 0, 1);

    // ignored controls: din_valid alone in IDLE, start mid-frame
    step(0, 0, 1, 1, 0);
    chk("ign_ovr_idle", int'(overrun), 1);
    step(0, 1, 1, 1, 0);
    chk("ign_ovr_start", int'(overrun), 0);
    chk("ign_busy", int'(busy), 1);
    w96 = 8'h96;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      step(0, (i == 4), 1, w96[i], 0);
      chk("ign_ovr_frame", int'(overrun), 0);
    end
    step(0, 0, 1, 0, 0);
    chk("ign_word", int'(word_out), 'h96);
    chk("ign_perr", int'(parity_err), 0);
    step(0, 0, 0, 0, 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 1) == 1));
    end
    step(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
